// File: rtl/lzc_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lzc_arb_pkg
// Shared types and helpers for the round-robin arbiter.
//   arb_state_e : lock FSM states (idle / locked on a stalled winner)
//   idx_width() : index width for n requesters, never less than 1 bit
// -----------------------------------------------------------------------------
package lzc_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lzc_rr_arbiter_lzc.sv
// -----------------------------------------------------------------------------
// lzc
// Leading/trailing zero counter.
//   in_i    : input vector
//   cnt_o   : MODE=0 -> number of trailing zeros (index of lowest set bit)
//             MODE=1 -> number of leading zeros
//             Reads 0 when the input is all-zero; qualify with empty_o.
//   empty_o : input vector is all-zero
// -----------------------------------------------------------------------------
module lzc #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Scan so that the bit nearest the counted end is written last and wins.
    always_comb begin
        cnt_o = '0;
        if (!MODE) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
                end
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/lzc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// lzc_rr_arbiter
// Round-robin arbiter sharing one downstream req/gnt port among NUM_REQ
// requesters. Starvation-free rotation; optionally holds its selection while
// the downstream port stalls.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : return pointer and lock FSM to their reset state
//   req_i        : per-requester request
//   data_i       : per-requester payload
//   gnt_o        : one-hot grant to the selected requester (only with gnt_i)
//   req_o        : downstream request (OR of all requests)
//   data_o       : payload of the selected requester
//   idx_o        : index of the selected requester
//   gnt_i        : downstream grant; transfer completes on req_o && gnt_i
// -----------------------------------------------------------------------------
module lzc_rr_arbiter
    import lzc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          LOCK_IN    = 1'b1,
    parameter int unsigned IDX_WIDTH  = idx_width(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    output logic                                 req_o,
    output logic [DATA_WIDTH-1:0]                data_o,
    output logic [IDX_WIDTH-1:0]                 idx_o,
    input  logic                                 gnt_i
);

    localparam int unsigned          CNT_W   = idx_width(2 * NUM_REQ);
    localparam logic [IDX_WIDTH-1:0] PTR_RST = IDX_WIDTH'(NUM_REQ - 1);

    arb_state_e           state_q;
    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH-1:0] lock_idx_q;

    logic [IDX_WIDTH-1:0] w_winner;
    logic                 w_found;

    generate
        if (NUM_REQ > 1) begin : g_arb
            localparam logic [CNT_W-1:0] NUM_REQ_C = CNT_W'(NUM_REQ);

            logic [NUM_REQ-1:0] w_mask;
            logic [NUM_REQ-1:0] w_masked;
            logic [CNT_W-1:0]   w_cnt;
            logic               w_empty;

            // Only requesters strictly after the last winner are eligible in
            // the low half; the unmasked copy in the high half supplies the
            // wrap-around candidate.
            always_comb begin
                w_mask = '0;
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    w_mask[i] = (i > int'(ptr_q));
                end
            end

            assign w_masked = req_i & w_mask;

            lzc #(
                .WIDTH (2 * NUM_REQ),
                .MODE  (1'b0)
            ) i_lzc (
                .in_i    ({req_i, w_masked}),
                .cnt_o   (w_cnt),
                .empty_o (w_empty)
            );

            always_comb begin
                if (w_cnt < NUM_REQ_C) begin
                    w_winner = IDX_WIDTH'(w_cnt);
                end else begin
                    w_winner = IDX_WIDTH'(w_cnt - NUM_REQ_C);
                end
            end

            assign w_found = !w_empty;
        end else begin : g_single
            assign w_winner = '0;
            assign w_found  = req_i[0];
        end
    endgenerate

    assign req_o = |req_i;

    // With no request pending, idx_o falls back to the held lock index so it
    // never floats to X.
    always_comb begin
        if (state_q == ARB_LOCKED) begin
            idx_o = lock_idx_q;
        end else if (w_found) begin
            idx_o = w_winner;
        end else begin
            idx_o = lock_idx_q;
        end
    end

    assign data_o = data_i[idx_o];

    always_comb begin
        gnt_o        = '0;
        gnt_o[idx_o] = req_o && gnt_i;
    end

    // Flush still lets a same-cycle handshake through on gnt_o, but the
    // pointer returns to its reset value rather than recording that winner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= PTR_RST;
            lock_idx_q <= '0;
        end else if (flush_i) begin
            state_q <= ARB_IDLE;
            ptr_q   <= PTR_RST;
        end else begin
            if (req_o && gnt_i) begin
                ptr_q <= idx_o;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (LOCK_IN && req_o && !gnt_i) begin
                        state_q    <= ARB_LOCKED;
                        lock_idx_q <= w_winner;
                    end
                end
                ARB_LOCKED: begin
                    // A dropped locked request is a protocol error; recover by
                    // releasing the lock rather than granting a stale index.
                    if (gnt_i || !req_i[lock_idx_q]) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_rr_arbiter.sv
module tb_lzc_rr_arbiter;
    import lzc_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    // 8-requester instance, lock enabled
    logic [7:0]       req8;
    logic [7:0][31:0] data8;
    logic [7:0]       gnt8_o;
    logic             reqo8;
    logic [31:0]      datao8;
    logic [2:0]       idx8;
    logic             gnt8_i;

    // 5-requester instance (non power of two)
    logic [4:0]       req5;
    logic [4:0][31:0] data5;
    logic [4:0]       gnt5_o;
    logic             reqo5;
    logic [31:0]      datao5;
    logic [2:0]       idx5;
    logic             gnt5_i;

    lzc_rr_arbiter #(.NUM_REQ(8), .DATA_WIDTH(32), .LOCK_IN(1'b1)) dut8 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req8), .data_i(data8),
        .gnt_o(gnt8_o), .req_o(reqo8), .data_o(datao8), .idx_o(idx8), .gnt_i(gnt8_i)
    );

    lzc_rr_arbiter #(.NUM_REQ(5), .DATA_WIDTH(32), .LOCK_IN(1'b1)) dut5 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req5), .data_i(data5),
        .gnt_o(gnt5_o), .req_o(reqo5), .data_o(datao5), .idx_o(idx5), .gnt_i(gnt5_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Requester protocol: a locked, un-granted request must stay asserted.
    always @(negedge clk) begin
        if (!rst && !flush && dut8.state_q == ARB_LOCKED && !gnt8_i && !req8[dut8.lock_idx_q]) begin
            errors++;
            $display("FAIL req_drop_while_locked actual=%0h required=1", req8[dut8.lock_idx_q]);
        end
    end

    typedef struct {
        logic       rst;
        logic       flush;
        logic [7:0] req;
        logic       gnt;
        logic       exp_reqo;
        logic [2:0] exp_idx;
        logic [7:0] exp_gnt;
        logic [2:0] exp_ptr;   // after the clock edge
        arb_state_e exp_st;    // after the clock edge
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic [7:0] q, logic g, logic ro,
                                logic [2:0] ix, logic [7:0] go, logic [2:0] p, arb_state_e s);
        vec_t v;
        v.rst = r; v.flush = f; v.req = q; v.gnt = g; v.exp_reqo = ro;
        v.exp_idx = ix; v.exp_gnt = go; v.exp_ptr = p; v.exp_st = s;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        for (int k = 0; k < 8; k++) data8[k] = 32'hA000_0000 + k;
        for (int k = 0; k < 5; k++) data5[k] = 32'hB000_0000 + k;

        // Reset state
        tbl[0] = mk(0, 0, 8'h00, 0, 0, 3'd0, 8'h00, 3'd7, ARB_IDLE);
        // Full request with gnt held: 0..7 then wrap to 0
        for (int k = 0; k < 9; k++) begin
            tbl[1+k] = mk(0, 0, 8'hFF, 1, 1, 3'(k % 8), 8'(1 << (k % 8)), 3'(k % 8), ARB_IDLE);
        end
        // Move ptr to 5, then wrap to 0, then back to 5
        tbl[10] = mk(0, 0, 8'h20, 1, 1, 3'd5, 8'h20, 3'd5, ARB_IDLE);
        tbl[11] = mk(0, 0, 8'h21, 1, 1, 3'd0, 8'h01, 3'd0, ARB_IDLE);
        tbl[12] = mk(0, 0, 8'h21, 1, 1, 3'd5, 8'h20, 3'd5, ARB_IDLE);
        // Lock on 2 while stalled; higher priority 0 arriving does not steal
        tbl[13] = mk(0, 0, 8'h04, 0, 1, 3'd2, 8'h00, 3'd5, ARB_LOCKED);
        tbl[14] = mk(0, 0, 8'h04, 0, 1, 3'd2, 8'h00, 3'd5, ARB_LOCKED);
        tbl[15] = mk(0, 0, 8'h04, 0, 1, 3'd2, 8'h00, 3'd5, ARB_LOCKED);
        tbl[16] = mk(0, 0, 8'h05, 0, 1, 3'd2, 8'h00, 3'd5, ARB_LOCKED);
        tbl[17] = mk(0, 0, 8'h05, 1, 1, 3'd2, 8'h04, 3'd2, ARB_IDLE);
        tbl[18] = mk(0, 0, 8'h05, 0, 1, 3'd0, 8'h00, 3'd2, ARB_LOCKED);
        tbl[19] = mk(0, 0, 8'h01, 1, 1, 3'd0, 8'h01, 3'd0, ARB_IDLE);
        // Lock on 3, then flush together with a grant
        tbl[20] = mk(0, 0, 8'h08, 0, 1, 3'd3, 8'h00, 3'd0, ARB_LOCKED);
        tbl[21] = mk(0, 0, 8'h0C, 0, 1, 3'd3, 8'h00, 3'd0, ARB_LOCKED);
        tbl[22] = mk(0, 1, 8'h0C, 1, 1, 3'd3, 8'h08, 3'd7, ARB_IDLE);
        // Lock on 4, then reset while locked
        tbl[23] = mk(0, 0, 8'h10, 0, 1, 3'd4, 8'h00, 3'd7, ARB_LOCKED);
        tbl[24] = mk(1, 0, 8'h10, 0, 1, 3'd4, 8'h00, 3'd7, ARB_IDLE);
        tbl[25] = mk(0, 0, 8'h00, 0, 0, 3'd0, 8'h00, 3'd7, ARB_IDLE);

        // Initial reset of both instances
        rst = 1'b1; flush = 1'b0;
        req8 = '0; gnt8_i = 1'b0; req5 = '0; gnt5_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ptr8", 64'(dut8.ptr_q), 64'd7);
        chk("rst_state8", 64'(dut8.state_q), 64'(ARB_IDLE));
        chk("rst_ptr5", 64'(dut5.ptr_q), 64'd4);

        for (int r = 0; r < 26; r++) begin
            rst    = tbl[r].rst;
            flush  = tbl[r].flush;
            req8   = tbl[r].req;
            gnt8_i = tbl[r].gnt;
            #1;
            chk($sformatf("row%0d req_o", r), 64'(reqo8), 64'(tbl[r].exp_reqo));
            chk($sformatf("row%0d idx_o", r), 64'(idx8), 64'(tbl[r].exp_idx));
            chk($sformatf("row%0d gnt_o", r), 64'(gnt8_o), 64'(tbl[r].exp_gnt));
            chk($sformatf("row%0d data_o", r), 64'(datao8), 64'(32'hA000_0000 + 32'(tbl[r].exp_idx)));
            @(posedge clk); #1;
            chk($sformatf("row%0d ptr_q", r), 64'(dut8.ptr_q), 64'(tbl[r].exp_ptr));
            chk($sformatf("row%0d state_q", r), 64'(dut8.state_q), 64'(tbl[r].exp_st));
        end
        rst = 1'b0; flush = 1'b0; req8 = '0; gnt8_i = 1'b0;

        // NUM_REQ = 5: top requester only, granted repeatedly
        req5 = 5'b10000; gnt5_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("n5_%0d idx_o", k), 64'(idx5), 64'd4);
            chk($sformatf("n5_%0d gnt_o", k), 64'(gnt5_o), 64'h10);
            chk($sformatf("n5_%0d data_o", k), 64'(datao5), 64'hB000_0004);
            chk($sformatf("n5_%0d no_x", k), 64'($isunknown({gnt5_o, reqo5, datao5, idx5})), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("n5_%0d ptr_q", k), 64'(dut5.ptr_q), 64'd4);
        end
        // NUM_REQ = 5: wrap from ptr 4 to requester 1
        req5 = 5'b10010;
        #1;
        chk("n5_wrap idx_o", 64'(idx5), 64'd1);
        chk("n5_wrap gnt_o", 64'(gnt5_o), 64'h02);
        @(posedge clk); #1;
        chk("n5_wrap ptr_q", 64'(dut5.ptr_q), 64'd1);
        req5 = '0; gnt5_i = 1'b0;
        #1;
        chk("n5_idle gnt_o", 64'(gnt5_o), 64'd0);
        chk("n5_idle no_x", 64'($isunknown({gnt5_o, reqo5, datao5, idx5})), 64'd0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
